// File: rtl/vproc_div_iter_if.sv
// Shared types and the request/result interface of the iterative vector divider.
// The element-width encoding is kept here so producer, divider and consumer agree on it.

package vproc_div_pkg;
    typedef enum logic [1:0] {
        VSEW_8   = 2'b00,
        VSEW_16  = 2'b01,
        VSEW_32  = 2'b10,
        VSEW_INV = 2'b11
    } cfg_vsew;
endpackage

interface vproc_div_iter_if #(
    parameter int unsigned DIV_OP_W = 64,
    parameter type         CTRL_T   = logic
) ();
    import vproc_div_pkg::*;

    logic                  abort;
    logic                  in_valid;
    logic                  in_ready;
    CTRL_T                 in_ctrl;
    cfg_vsew               in_eew;
    logic                  in_signed;
    logic                  in_rem;
    logic [DIV_OP_W-1:0]   in_op1;
    logic [DIV_OP_W-1:0]   in_op2;
    logic [DIV_OP_W/8-1:0] in_mask;
    logic                  out_valid;
    logic                  out_ready;
    CTRL_T                 out_ctrl;
    logic [DIV_OP_W-1:0]   out_res;
    logic [DIV_OP_W/8-1:0] out_mask;
    logic                  busy;

    modport master (
        output abort, in_valid, in_ctrl, in_eew, in_signed, in_rem, in_op1, in_op2, in_mask, out_ready,
        input  in_ready, out_valid, out_ctrl, out_res, out_mask, busy
    );

    modport slave (
        input  abort, in_valid, in_ctrl, in_eew, in_signed, in_rem, in_op1, in_op2, in_mask, out_ready,
        output in_ready, out_valid, out_ctrl, out_res, out_mask, busy
    );
endinterface

// File: rtl/vproc_div_iter.sv
// Iterative SIMD integer divider: one shared restoring datapath with DIV_OP_W/8 slots of 32 bits,
// each retiring UNROLL quotient bits per cycle. Operands are reduced to magnitudes on accept and
// the signs are re-applied in a single fix-up cycle before the result is registered.

module vproc_div_iter #(
    parameter int unsigned DIV_OP_W = 64,
    parameter int unsigned UNROLL   = 1,
    parameter type         CTRL_T   = logic
) (
    input  logic            clk_i,
    input  logic            async_rst_ni,
    vproc_div_iter_if.slave div_if
);
    import vproc_div_pkg::*;

    localparam int unsigned NSLOT = DIV_OP_W / 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    state_e              state_r, state_nxt_s;
    logic                in_ready_s, accept_s;
    cfg_vsew             eew_in_s, sew_r;
    logic [5:0]          cnt_r;
    CTRL_T               ctrl_r;
    logic [NSLOT-1:0]    mask_r, qneg_r, rneg_r, qneg_in_s, rneg_in_s;
    logic                rem_r;
    logic [31:0]         rq_r [NSLOT];
    logic [31:0]         q_r [NSLOT];
    logic [31:0]         d_r [NSLOT];
    logic [31:0]         rq_nxt_s [NSLOT];
    logic [31:0]         q_nxt_s [NSLOT];
    logic [31:0]         q_in_s [NSLOT];
    logic [31:0]         d_in_s [NSLOT];
    logic [DIV_OP_W-1:0] res_s, out_res_r;

    // Unsupported widths fold onto 32 bit
    function automatic cfg_vsew sew_norm(input cfg_vsew e);
        case (e)
            VSEW_8:  return VSEW_8;
            VSEW_16: return VSEW_16;
            default: return VSEW_32;
        endcase
    endfunction

    function automatic int unsigned sew_bits(input cfg_vsew e);
        case (e)
            VSEW_8:  return 8;
            VSEW_16: return 16;
            default: return 32;
        endcase
    endfunction

    function automatic logic [31:0] sew_mask(input cfg_vsew e);
        case (e)
            VSEW_8:  return 32'h0000_00FF;
            VSEW_16: return 32'h0000_FFFF;
            default: return 32'hFFFF_FFFF;
        endcase
    endfunction

    // Element i of a vector, zero-extended; slots without an element read as zero
    function automatic logic [31:0] get_elem(input logic [DIV_OP_W-1:0] v, input cfg_vsew e,
                                             input int unsigned i);
        logic [DIV_OP_W-1:0] sh;
        sh = v >> (i * sew_bits(e));
        if (i < (DIV_OP_W / sew_bits(e))) begin
            return sh[31:0] & sew_mask(e);
        end else begin
            return 32'd0;
        end
    endfunction

    function automatic logic sign_of(input logic [31:0] x, input cfg_vsew e);
        case (e)
            VSEW_8:  return x[7];
            VSEW_16: return x[15];
            default: return x[31];
        endcase
    endfunction

    assign eew_in_s = sew_norm(div_if.in_eew);
    assign accept_s = div_if.in_valid & in_ready_s & ~div_if.abort;

    // Operand magnitudes per slot; the dividend is left-aligned so every width shifts from bit 31
    always_comb begin
        logic [31:0] e1_v, e2_v, m1_v, m2_v;
        logic        s1_v, s2_v;
        qneg_in_s = '0;
        rneg_in_s = '0;
        for (int i = 0; i < NSLOT; i++) begin
            e1_v = get_elem(div_if.in_op1, eew_in_s, i);
            e2_v = get_elem(div_if.in_op2, eew_in_s, i);
            s1_v = div_if.in_signed & sign_of(e1_v, eew_in_s);
            s2_v = div_if.in_signed & sign_of(e2_v, eew_in_s);
            m1_v = s1_v ? ((~e1_v + 32'd1) & sew_mask(eew_in_s)) : e1_v;
            m2_v = s2_v ? ((~e2_v + 32'd1) & sew_mask(eew_in_s)) : e2_v;
            q_in_s[i]    = m1_v << (32 - sew_bits(eew_in_s));
            d_in_s[i]    = m2_v;
            qneg_in_s[i] = s1_v ^ s2_v;
            rneg_in_s[i] = s1_v;
        end
    end

    // UNROLL restoring steps per slot for the current BUSY cycle
    always_comb begin
        logic [31:0] r_v, q_v;
        logic [32:0] t_v;
        for (int s = 0; s < NSLOT; s++) begin
            r_v = rq_r[s];
            q_v = q_r[s];
            t_v = 33'd0;
            for (int u = 0; u < UNROLL; u++) begin
                t_v = {r_v, q_v[31]};
                if (t_v >= {1'b0, d_r[s]}) begin
                    r_v = 32'(t_v - {1'b0, d_r[s]});
                    q_v = {q_v[30:0], 1'b1};
                end else begin
                    r_v = t_v[31:0];
                    q_v = {q_v[30:0], 1'b0};
                end
            end
            rq_nxt_s[s] = r_v;
            q_nxt_s[s]  = q_v;
        end
    end

    // Sign fix-up, quotient/remainder select and inactive-element zeroing
    always_comb begin
        logic [31:0]      val_v;
        logic             neg_v;
        logic [NSLOT-1:0] mbit_v;
        res_s = '0;
        for (int s = 0; s < NSLOT; s++) begin
            val_v  = rem_r ? rq_r[s] : q_r[s];
            // A zero divisor keeps the all-ones quotient; the remainder still returns the dividend
            neg_v  = rem_r ? rneg_r[s] : (qneg_r[s] & (d_r[s] != 32'd0));
            if (neg_v) begin
                val_v = ~val_v + 32'd1;
            end else begin
                val_v = val_v;
            end
            val_v  = val_v & sew_mask(sew_r);
            mbit_v = mask_r >> (s * (sew_bits(sew_r) / 8));
            if ((s < (DIV_OP_W / sew_bits(sew_r))) && mbit_v[0]) begin
                res_s = res_s | (DIV_OP_W'(val_v) << (s * sew_bits(sew_r)));
            end else begin
                res_s = res_s;
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk_i or negedge async_rst_ni) begin
        if (!async_rst_ni) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next state; abort overrides every handshake
    always_comb begin
        state_nxt_s = state_r;
        if (div_if.abort) begin
            state_nxt_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: state_nxt_s = accept_s ? ST_BUSY : ST_IDLE;
                ST_BUSY: state_nxt_s = (cnt_r == 6'd0) ? ST_FIX : ST_BUSY;
                ST_FIX:  state_nxt_s = ST_DONE;
                ST_DONE: begin
                    if (accept_s) begin
                        state_nxt_s = ST_BUSY;
                    end else if (div_if.out_ready) begin
                        state_nxt_s = ST_IDLE;
                    end else begin
                        state_nxt_s = ST_DONE;
                    end
                end
                default: state_nxt_s = ST_IDLE;
            endcase
        end
    end

    // FSM outputs decoded from the state register
    always_comb begin
        in_ready_s       = (state_r == ST_IDLE) | ((state_r == ST_DONE) & div_if.out_ready);
        div_if.out_valid = (state_r == ST_DONE);
        div_if.busy      = (state_r != ST_IDLE);
    end

    assign div_if.in_ready = in_ready_s;
    assign div_if.out_ctrl = ctrl_r;
    assign div_if.out_mask = mask_r;
    assign div_if.out_res  = out_res_r;

    // Operand capture on accept and iteration while BUSY
    always_ff @(posedge clk_i or negedge async_rst_ni) begin
        if (!async_rst_ni) begin
            cnt_r  <= 6'd0;
            ctrl_r <= '0;
            mask_r <= '0;
            sew_r  <= VSEW_32;
            rem_r  <= 1'b0;
            qneg_r <= '0;
            rneg_r <= '0;
            for (int s = 0; s < NSLOT; s++) begin
                rq_r[s] <= 32'd0;
                q_r[s]  <= 32'd0;
                d_r[s]  <= 32'd0;
            end
        end else if (accept_s) begin
            cnt_r  <= 6'(sew_bits(eew_in_s) / UNROLL - 1);
            ctrl_r <= div_if.in_ctrl;
            mask_r <= div_if.in_mask;
            sew_r  <= eew_in_s;
            rem_r  <= div_if.in_rem;
            qneg_r <= qneg_in_s;
            rneg_r <= rneg_in_s;
            for (int s = 0; s < NSLOT; s++) begin
                rq_r[s] <= 32'd0;
                q_r[s]  <= q_in_s[s];
                d_r[s]  <= d_in_s[s];
            end
        end else if (state_r == ST_BUSY) begin
            cnt_r <= (cnt_r == 6'd0) ? 6'd0 : cnt_r - 6'd1;
            rq_r  <= rq_nxt_s;
            q_r   <= q_nxt_s;
        end
    end

    // Result register, written only in the fix-up cycle
    always_ff @(posedge clk_i or negedge async_rst_ni) begin
        if (!async_rst_ni) begin
            out_res_r <= '0;
        end else if ((state_r == ST_FIX) && !div_if.abort) begin
            out_res_r <= res_s;
        end
    end
endmodule

// File: tb/tb_vproc_div_iter.sv
// Self-checking bench for vproc_div_iter: directed vector table, handshake/abort/reset
// sequences and randomized operations against an arithmetic reference model.
`timescale 1ns/1ps

module tb_vproc_div_iter;
    import vproc_div_pkg::*;

    localparam int W   = 64;
    localparam int UNR = 1;

    typedef struct {
        cfg_vsew     eew;
        bit          sgn;
        bit          rem;
        logic [63:0] op1;
        logic [63:0] op2;
        logic [7:0]  mask;
        logic [63:0] exp;
    } vec_t;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    int   cyc;
    vec_t vecs [13];

    vproc_div_iter_if #(.DIV_OP_W(W), .CTRL_T(logic [7:0])) div_if ();

    vproc_div_iter #(.DIV_OP_W(W), .UNROLL(UNR), .CTRL_T(logic [7:0])) dut (
        .clk_i        (clk),
        .async_rst_ni (rst_n),
        .div_if       (div_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int sew_of(input cfg_vsew e);
        case (e)
            VSEW_8:  return 8;
            VSEW_16: return 16;
            default: return 32;
        endcase
    endfunction

    // Reference: per-element integer arithmetic with the RISC-V division corner rules
    function automatic logic [63:0] model(input cfg_vsew e, input bit s, input bit r,
                                          input logic [63:0] a, input logic [63:0] b,
                                          input logic [7:0] m);
        int          sew = sew_of(e);
        logic [63:0] res = 64'd0;
        longint      mx  = (longint'(1) <<< sew) - 1;
        longint      half = longint'(1) <<< (sew - 1);
        for (int i = 0; i < 64 / sew; i++) begin
            longint ua, ub, q, rm;
            ua = longint'(a >> (i * sew)) & mx;
            ub = longint'(b >> (i * sew)) & mx;
            if (s && ua >= half) ua = ua - (mx + 1);
            if (s && ub >= half) ub = ub - (mx + 1);
            if (ub == 0) begin
                q  = -1;
                rm = ua;
            end else if (s && ub == -1 && ua == -half) begin
                q  = ua;
                rm = 0;
            end else begin
                q  = ua / ub;
                rm = ua % ub;
            end
            if (m[i * sew / 8]) res = res | (64'((r ? rm : q) & mx) << (i * sew));
        end
        return res;
    endfunction

    task automatic drive(input cfg_vsew e, input bit s, input bit r, input logic [63:0] a,
                         input logic [63:0] b, input logic [7:0] m, input logic [7:0] c);
        div_if.in_valid  = 1'b1;
        div_if.in_eew    = e;
        div_if.in_signed = s;
        div_if.in_rem    = r;
        div_if.in_op1    = a;
        div_if.in_op2    = b;
        div_if.in_mask   = m;
        div_if.in_ctrl   = c;
    endtask

    // Drop the request and garble the inputs; the captured operation must not notice
    task automatic scramble();
        div_if.in_valid  = 1'b0;
        div_if.in_op1    = {$urandom, $urandom};
        div_if.in_op2    = {$urandom, $urandom};
        div_if.in_mask   = 8'($urandom);
        div_if.in_ctrl   = 8'($urandom);
        div_if.in_signed = 1'($urandom);
        div_if.in_rem    = 1'($urandom);
        div_if.in_eew    = cfg_vsew'($urandom_range(0, 3));
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!div_if.out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic run_op(input string name, input cfg_vsew e, input bit s, input bit r,
                          input logic [63:0] a, input logic [63:0] b, input logic [7:0] m,
                          input logic [63:0] exp, input int stall);
        logic [7:0] c;
        int         k, n;
        c = 8'($urandom);
        @(negedge clk);
        drive(e, s, r, a, b, m, c);
        k = 0;
        while (!div_if.in_ready && k < 100) begin
            @(negedge clk);
            k++;
        end
        @(posedge clk);
        @(negedge clk);
        scramble();
        wait_valid(n);
        check({name, "_lat"}, 64'(n), 64'(sew_of(e) / UNR + 1));
        check({name, "_res"}, div_if.out_res, exp);
        check({name, "_mask"}, 64'(div_if.out_mask), 64'(m));
        check({name, "_ctrl"}, 64'(div_if.out_ctrl), 64'(c));
        repeat (stall) @(negedge clk);
        if (stall > 0) check({name, "_hold"}, div_if.out_res, exp);
        div_if.out_ready = 1'b1;
        @(negedge clk);
        div_if.out_ready = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{VSEW_8,   1'b0, 1'b0, 64'h0000_0000_0000_00C8, 64'h0101_0101_0101_0107, 8'hFF, 64'h0000_0000_0000_001C};
        vecs[1]  = '{VSEW_16,  1'b1, 1'b0, 64'h0000_0000_0000_FFF9, 64'h0001_0001_0001_0002, 8'hFF, 64'h0000_0000_0000_FFFD};
        vecs[2]  = '{VSEW_16,  1'b1, 1'b1, 64'h0000_0000_0000_FFF9, 64'h0001_0001_0001_0002, 8'hFF, 64'h0000_0000_0000_FFFF};
        vecs[3]  = '{VSEW_32,  1'b1, 1'b0, 64'h0000_0000_0000_0005, 64'h0000_0000_0000_0000, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF};
        vecs[4]  = '{VSEW_32,  1'b1, 1'b1, 64'h0000_0000_0000_0005, 64'h0000_0000_0000_0000, 8'hFF, 64'h0000_0000_0000_0005};
        vecs[5]  = '{VSEW_8,   1'b1, 1'b0, 64'h1020_3040_5060_7080, 64'h0102_0304_0506_07FF, 8'hFF, 64'h1010_1010_1010_1080};
        vecs[6]  = '{VSEW_8,   1'b1, 1'b1, 64'h1020_3040_5060_7080, 64'h0102_0304_0506_07FF, 8'hFF, 64'h0000_0000_0000_0000};
        vecs[7]  = '{VSEW_8,   1'b1, 1'b0, 64'h1020_3040_5060_7080, 64'h0102_0304_0506_07FF, 8'hFE, 64'h1010_1010_1010_1000};
        vecs[8]  = '{VSEW_16,  1'b0, 1'b0, 64'h0064_0064_0064_0064, 64'h0003_0003_0003_0003, 8'hFB, 64'h0021_0021_0000_0021};
        vecs[9]  = '{VSEW_INV, 1'b1, 1'b1, 64'h0000_0064_FFFF_FF9C, 64'h0000_0007_0000_0007, 8'hFF, 64'h0000_0002_FFFF_FFFE};
        vecs[10] = '{VSEW_32,  1'b1, 1'b0, 64'h0000_0064_FFFF_FF9C, 64'hFFFF_FFF9_0000_0007, 8'hFF, 64'hFFFF_FFF2_FFFF_FFF2};
        vecs[11] = '{VSEW_8,   1'b1, 1'b1, 64'h0000_0000_0000_00F9, 64'h0101_0101_0101_0100, 8'hFF, 64'h0000_0000_0000_00F9};
        vecs[12] = '{VSEW_8,   1'b1, 1'b0, 64'h0000_0000_0000_00F9, 64'h0101_0101_0101_0100, 8'hFF, 64'h0000_0000_0000_00FF};

        rst_n = 1'b0;
        div_if.abort     = 1'b0;
        div_if.out_ready = 1'b0;
        scramble();
        #12;
        check("rst_out_valid", 64'(div_if.out_valid), 64'd0);
        check("rst_busy", 64'(div_if.busy), 64'd0);
        check("rst_in_ready", 64'(div_if.in_ready), 64'd1);
        check("rst_out_res", div_if.out_res, 64'd0);
        check("rst_out_mask", 64'(div_if.out_mask), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors
        for (int i = 0; i < 13; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].eew, vecs[i].sgn, vecs[i].rem,
                   vecs[i].op1, vecs[i].op2, vecs[i].mask, vecs[i].exp, 0);
        end

        // Stall with out_ready low, then back-to-back accept on release
        @(negedge clk);
        drive(VSEW_8, 1'b0, 1'b0, 64'h0000_0000_0000_00C8, 64'h0101_0101_0101_0107, 8'hFF, 8'h5A);
        @(posedge clk);
        @(negedge clk);
        scramble();
        wait_valid(cyc);
        check("stall_lat", 64'(cyc), 64'd9);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("stall_res", div_if.out_res, 64'h1C);
            check("stall_valid", 64'(div_if.out_valid), 64'd1);
            check("stall_ctrl", 64'(div_if.out_ctrl), 64'h5A);
        end
        drive(VSEW_8, 1'b0, 1'b0, 64'h0000_0000_0000_00F0, 64'h0101_0101_0101_010F, 8'hFF, 8'hA5);
        div_if.out_ready = 1'b1;
        #1;
        check("b2b_in_ready", 64'(div_if.in_ready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        div_if.out_ready = 1'b0;
        scramble();
        check("b2b_busy", 64'(div_if.busy), 64'd1);
        check("b2b_valid_low", 64'(div_if.out_valid), 64'd0);
        wait_valid(cyc);
        check("b2b_lat", 64'(cyc), 64'd9);
        check("b2b_res", div_if.out_res, 64'h10);
        check("b2b_ctrl", 64'(div_if.out_ctrl), 64'hA5);
        div_if.out_ready = 1'b1;
        @(negedge clk);
        div_if.out_ready = 1'b0;

        // Abort mid-BUSY
        drive(VSEW_16, 1'b0, 1'b0, 64'h0064_0064_0064_0064, 64'h0003_0003_0003_0003, 8'hFF, 8'h11);
        @(posedge clk);
        @(negedge clk);
        scramble();
        repeat (3) @(negedge clk);
        div_if.abort = 1'b1;
        div_if.in_valid = 1'b1;
        @(negedge clk);
        div_if.abort = 1'b0;
        div_if.in_valid = 1'b0;
        check("abort_busy_valid", 64'(div_if.out_valid), 64'd0);
        check("abort_busy_ready", 64'(div_if.in_ready), 64'd1);
        check("abort_busy_busy", 64'(div_if.busy), 64'd0);
        run_op("post_abort", VSEW_16, 1'b1, 1'b0, 64'h0000_0000_0000_FFF9, 64'h0001_0001_0001_0002,
               8'hFF, 64'h0000_0000_0000_FFFD, 2);

        // Abort in DONE while a new request is offered: the request must be dropped
        drive(VSEW_8, 1'b0, 1'b0, 64'h0000_0000_0000_00C8, 64'h0101_0101_0101_0107, 8'hFF, 8'h22);
        @(posedge clk);
        @(negedge clk);
        scramble();
        wait_valid(cyc);
        check("abort_done_lat", 64'(cyc), 64'd9);
        div_if.abort = 1'b1;
        div_if.out_ready = 1'b1;
        drive(VSEW_8, 1'b0, 1'b0, 64'h0000_0000_0000_0050, 64'h0101_0101_0101_0105, 8'hFF, 8'h33);
        @(negedge clk);
        div_if.abort = 1'b0;
        div_if.out_ready = 1'b0;
        div_if.in_valid = 1'b0;
        check("abort_done_valid", 64'(div_if.out_valid), 64'd0);
        check("abort_done_busy", 64'(div_if.busy), 64'd0);
        repeat (12) @(negedge clk);
        check("abort_done_no_accept", 64'(div_if.busy | div_if.out_valid), 64'd0);

        // Async reset mid-BUSY
        drive(VSEW_32, 1'b0, 1'b0, 64'h0000_0064_0000_0064, 64'h0000_0003_0000_0003, 8'hFF, 8'h44);
        @(posedge clk);
        @(negedge clk);
        scramble();
        repeat (4) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", 64'(div_if.out_valid), 64'd0);
        check("arst_busy", 64'(div_if.busy), 64'd0);
        check("arst_ready", 64'(div_if.in_ready), 64'd1);
        check("arst_res", div_if.out_res, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("post_arst", VSEW_32, 1'b0, 1'b0, 64'h0000_0064_0000_0064, 64'h0000_0003_0000_0003,
               8'hFF, 64'h0000_0021_0000_0021, 0);

        // Randomized operations against the reference model
        for (int t = 0; t < 60; t++) begin
            cfg_vsew     e;
            bit          s, r;
            logic [63:0] a, b;
            logic [7:0]  m;
            e = cfg_vsew'($urandom_range(0, 3));
            s = 1'($urandom);
            r = 1'($urandom);
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            m = 8'($urandom);
            case ($urandom_range(0, 3))
                0: b = b;
                1: b = b & 64'h0F0F_0F0F_0F0F_0F0F;
                2: begin
                    a = 64'h8080_8080_8000_0000;
                    b = 64'hFFFF_FFFF_FFFF_FFFF;
                end
                default: b = b & {$urandom, $urandom} & {$urandom, $urandom};
            endcase
            run_op($sformatf("rnd%0d", t), e, s, r, a, b, m, model(e, s, r, a, b, m),
                   $urandom_range(0, 2));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
